snoop_bus_controller: RTL

//   Shared coherence bus and main memory that sit downstream of the per-CPU MSI cache controllers.
//   - Consumes each CPU's readMiss / writeMiss / invalidate / writeBack requests.
//   - Arbitrates round-robin and broadcasts the winner to every cache as a snoop.
//   - Collects write-back data from a Modified owner.
//   - Returns fill data from memory, or forwards it directly from the owner.

---
 rtl/snoop_bus_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/snoop_bus_controller.sv
// snoop_bus_controller: round-robin snoop bus with write-back capture and latency-modelled main memory
module snoop_bus_controller #(
    parameter int NUM_CPUS = 2,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 4,
    parameter int MEM_LAT  = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_CPUS-1:0]          req_valid,
    input  logic [2*NUM_CPUS-1:0]        req_type,
    input  logic [ADDR_W*NUM_CPUS-1:0]   req_addr,
    input  logic [DATA_W*NUM_CPUS-1:0]   req_wdata,
    output logic [NUM_CPUS-1:0]          done,
    output logic [DATA_W-1:0]            resp_data,
    output logic                         snoop_valid,
    output logic [1:0]                   snoop_type,
    output logic [ADDR_W-1:0]            snoop_addr,
    output logic [$clog2(NUM_CPUS)-1:0]  snoop_src,
    input  logic [NUM_CPUS-1:0]          snoop_wb_valid,
    input  logic [DATA_W*NUM_CPUS-1:0]   snoop_wb_data,
    output logic                         busy,
    output logic                         proto_err
);
    localparam int IW = $clog2(NUM_CPUS);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {IDLE, WB, BCAST, SNOOP, MEM, RESP} state_t;

    state_t            state, next;
    logic [IW-1:0]     ptr, win, owner, hit;
    logic [1:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, fill;
    logic [CW-1:0]     cnt;
    logic [NUM_CPUS-1:0] others;
    logic              multi;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        win = ptr;
        for (int k = NUM_CPUS - 1; k >= 0; k--)
            if (req_valid[ptr + IW'(k)]) win = ptr + IW'(k);
    end

    // the requester's own write-back flag is never a forwarding source
    assign others = snoop_wb_valid & ~(NUM_CPUS'(1) << owner);
    assign multi  = |(others & (others - NUM_CPUS'(1)));

    always_comb begin
        hit = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--)
            if (others[i]) hit = IW'(i);
    end

    always_ff @(posedge clock)
        state <= !reset_n ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !(|req_valid) ? IDLE : (req_type[win*2 +: 2] == 2'b11) ? WB : BCAST;
            WB:      next = RESP;
            BCAST:   next = (type_q == 2'b10) ? RESP : SNOOP;
            SNOOP:   next = (|others) ? RESP : MEM;
            MEM:     next = (cnt == CW'(MEM_LAT - 1)) ? RESP : MEM;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr       <= '0;
            owner     <= '0;
            type_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fill      <= '0;
            cnt       <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    owner   <= win;
                    ptr     <= win + IW'(1);
                    type_q  <= req_type[win*2 +: 2];
                    addr_q  <= req_addr[win*ADDR_W +: ADDR_W];
                    wdata_q <= req_wdata[win*DATA_W +: DATA_W];
                end
                WB: mem[addr_q] <= wdata_q;
                SNOOP: begin
                    cnt <= '0;
                    if (|others) begin
                        mem[addr_q] <= snoop_wb_data[hit*DATA_W +: DATA_W];
                        fill        <= snoop_wb_data[hit*DATA_W +: DATA_W];
                    end
                    if (multi) proto_err <= 1'b1;
                end
                MEM: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(MEM_LAT - 1)) fill <= mem[addr_q];
                end
                default: ;
            endcase
        end
    end

    assign busy        = state != IDLE;
    assign snoop_valid = state == BCAST;
    assign snoop_type  = snoop_valid ? type_q : '0;
    assign snoop_addr  = snoop_valid ? addr_q : '0;
    assign snoop_src   = snoop_valid ? owner : '0;
    assign done        = (state == RESP) ? NUM_CPUS'(1) << owner : '0;
    assign resp_data   = (state == RESP && !type_q[1]) ? fill : '0;
endmodule
